// File: rtl/rr_pkg.sv
// Shared constants and helpers for the round-robin dispatcher slice.
package rr_pkg;

    localparam int unsigned DefaultN = 3;
    localparam int unsigned CntW     = 16;

    // Pointer width; at least one bit so N=1 style corner builds stay legal.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_dispatch_slot.sv
// One-entry registered output slot for a single dispatcher channel.
module rr_dispatch_slot #(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          asrst_n,
    input  logic          load,
    input  logic [DW-1:0] din,
    input  logic          rdy,
    output logic          vld,
    output logic [DW-1:0] dout,
    output logic          free
);

    logic          vld_q;
    logic          vld_d;
    logic [DW-1:0] data_q;
    logic [DW-1:0] data_d;

    // A load wins over a same-cycle drain so the slot stays occupied.
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (load) begin
            vld_d  = 1'b1;
            data_d = din;
        end else if (vld_q && rdy) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge asrst_n) begin
        if (!asrst_n) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign vld  = vld_q;
    assign dout = data_q;
    assign free = !vld_q || rdy;

endmodule

// File: rtl/rr_dispatcher.sv
// Round-robin dispatcher: one valid/ready input spread over N registered output slots.
// Define RR_DISPATCHER_CNT_EN to add per-channel accept counters on o_cnt.
module rr_dispatcher
    import rr_pkg::*;
#(
    parameter int unsigned DW = 8,
    parameter int unsigned N  = DefaultN
) (
    input  logic            clk,
    input  logic            asrst_n,
    input  logic            en,
    input  logic            in_vld,
    input  logic [DW-1:0]   in_data,
    output logic            in_rdy,
    output logic [N-1:0]    out_vld,
    output logic [N*DW-1:0] out_data,
    input  logic [N-1:0]    out_rdy,
    output logic [N-1:0]    o_sel
`ifdef RR_DISPATCHER_CNT_EN
    ,
    output logic [N*CntW-1:0] o_cnt
`endif
);

    localparam int unsigned PW = ptr_width(N);

    logic [PW-1:0] last_ptr_q;
    logic [PW-1:0] last_ptr_d;
    logic [N-1:0]  free;
    logic [N-1:0]  sel_oh;
    logic [PW-1:0] sel_idx;
    logic [PW-1:0] cand;
    logic          found;
    logic          accept;

    // First free channel, searching from last_ptr+1 and wrapping modulo N.
    always_comb begin
        found   = 1'b0;
        sel_idx = '0;
        sel_oh  = '0;
        cand    = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand = PW'((32'(last_ptr_q) + i) % N);
            if (!found && free[cand]) begin
                found   = 1'b1;
                sel_idx = cand;
            end
        end
        if (found) begin
            sel_oh[sel_idx] = 1'b1;
        end
    end

    // Reset gating keeps the combinational handshake quiet while slots are held empty.
    assign in_rdy = asrst_n && en && found;
    assign accept = in_vld && in_rdy;
    assign o_sel  = accept ? sel_oh : '0;

    always_comb begin
        last_ptr_d = last_ptr_q;
        if (accept) begin
            last_ptr_d = sel_idx;
        end
    end

    always_ff @(posedge clk or negedge asrst_n) begin
        if (!asrst_n) begin
            last_ptr_q <= PW'(N - 1);
        end else begin
            last_ptr_q <= last_ptr_d;
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_slot
        rr_dispatch_slot #(
            .DW (DW)
        ) u_slot (
            .clk     (clk),
            .asrst_n (asrst_n),
            .load    (o_sel[k]),
            .din     (in_data),
            .rdy     (out_rdy[k]),
            .vld     (out_vld[k]),
            .dout    (out_data[k*DW +: DW]),
            .free    (free[k])
        );
    end

`ifdef RR_DISPATCHER_CNT_EN
    logic [N-1:0][CntW-1:0] cnt_q;
    logic [N-1:0][CntW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        for (int unsigned k = 0; k < N; k++) begin
            if (o_sel[k]) begin
                cnt_d[k] = cnt_q[k] + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge asrst_n) begin
        if (!asrst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt = cnt_q;
`endif

    a_sel_onehot0 : assert property (@(posedge clk) disable iff (!asrst_n) $onehot0(o_sel));
    a_accept_sel : assert property (@(posedge clk) disable iff (!asrst_n)
        accept |-> $onehot(o_sel));
    a_ptr_range : assert property (@(posedge clk) disable iff (!asrst_n)
        32'(last_ptr_q) < N);

endmodule

// File: tb/tb_rr_dispatcher.sv
// Scoreboard bench for rr_dispatcher: driver pushes expected words per channel,
// monitor pops and compares on every output handshake.
module tb_rr_dispatcher;

    localparam int DW = 8;
    localparam int N  = 3;

    logic            clk = 1'b0;
    logic            asrst_n;
    logic            en;
    logic            in_vld;
    logic [DW-1:0]   in_data;
    logic            in_rdy;
    logic [N-1:0]    out_vld;
    logic [N*DW-1:0] out_data;
    logic [N-1:0]    out_rdy;
    logic [N-1:0]    o_sel;
`ifdef RR_DISPATCHER_CNT_EN
    logic [N*16-1:0] o_cnt;
    logic [N*16-1:0] cnt_tmp;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int last_wait;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] q2[$];

    always #5 clk = ~clk;

    rr_dispatcher #(
        .DW (DW),
        .N  (N)
    ) dut (
        .clk      (clk),
        .asrst_n  (asrst_n),
        .en       (en),
        .in_vld   (in_vld),
        .in_data  (in_data),
        .in_rdy   (in_rdy),
        .out_vld  (out_vld),
        .out_data (out_data),
        .out_rdy  (out_rdy),
        .o_sel    (o_sel)
`ifdef RR_DISPATCHER_CNT_EN
        ,
        .o_cnt    (o_cnt)
`endif
    );

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    task automatic push_exp(input int ch, input logic [7:0] d);
        case (ch)
            0: q0.push_back(d);
            1: q1.push_back(d);
            default: q2.push_back(d);
        endcase
    endtask

    task automatic pop_exp(input int ch, output logic [7:0] d, output bit ok);
        ok = 1'b0;
        d  = '0;
        case (ch)
            0: if (q0.size() > 0) begin d = q0.pop_front(); ok = 1'b1; end
            1: if (q1.size() > 0) begin d = q1.pop_front(); ok = 1'b1; end
            default: if (q2.size() > 0) begin d = q2.pop_front(); ok = 1'b1; end
        endcase
    endtask

    task automatic flush();
        q0.delete();
        q1.delete();
        q2.delete();
    endtask

    // Called at a falling edge; returns at the falling edge after the accept.
    task automatic send(input logic [7:0] d, input int ch);
        logic [2:0] exp_oh;
        int n = 0;
        exp_oh = 3'b001 << ch;
        in_vld  = 1'b1;
        in_data = d;
        #1;
        while (!in_rdy && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        last_wait = n;
        if (!in_rdy) begin
            chk("accept_timeout", 48'd0, 48'd1);
            in_vld = 1'b0;
        end else begin
            chk("o_sel", 48'(o_sel), 48'(exp_oh));
            push_exp(ch, d);
            @(negedge clk);
            in_vld = 1'b0;
            chk("latency_vld", 48'(out_vld[ch]), 48'd1);
            chk("latency_data", 48'(out_data[ch*8 +: 8]), 48'(d));
        end
    endtask

    task automatic idle(input int cycles);
        in_vld = 1'b0;
        repeat (cycles) @(negedge clk);
    endtask

    always @(posedge clk) begin
        logic [7:0] exp_d;
        bit         ok;
        if (asrst_n) begin
            for (int k = 0; k < N; k++) begin
                if (out_vld[k] && out_rdy[k]) begin
                    pop_exp(k, exp_d, ok);
                    if (!ok) begin
                        n_chk++;
                        $display("FAIL drain_unexpected ch%0d: got %0h required no word",
                                 k, out_data[k*8 +: 8]);
                    end else begin
                        chk($sformatf("drain_ch%0d", k), 48'(out_data[k*8 +: 8]), 48'(exp_d));
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        asrst_n = 1'b0;
        en      = 1'b1;
        in_vld  = 1'b1;
        in_data = 8'hEE;
        out_rdy = 3'b000;
        #2;
        chk("rst_out_vld", 48'(out_vld), 48'd0);
        chk("rst_in_rdy", 48'(in_rdy), 48'd0);
        chk("rst_o_sel", 48'(o_sel), 48'd0);
        chk("rst_out_data", 48'(out_data), 48'd0);
        @(negedge clk);
        @(negedge clk);
        asrst_n = 1'b1;
        in_vld  = 1'b0;

        // Rotation with every consumer ready.
        out_rdy = 3'b111;
        for (int i = 0; i < 6; i++) begin
            send(8'hA0 + 8'(i), i % 3);
            chk("rot_no_stall", 48'(last_wait), 48'd0);
        end
        idle(1);

        // Skip occupied: build slot1 full with last_ptr=0.
        out_rdy = 3'b000;
        send(8'h40, 0);
        send(8'h41, 1);
        send(8'h42, 2);
        out_rdy = 3'b101;
        idle(1);
        out_rdy = 3'b000;
        send(8'h43, 0);
        out_rdy = 3'b001;
        idle(1);
        out_rdy = 3'b000;
        send(8'h5A, 2);
        send(8'h5B, 0);

        // Back-pressure: all full, word held until channel 1 frees.
        in_vld  = 1'b1;
        in_data = 8'h77;
        #1;
        chk("bp_in_rdy", 48'(in_rdy), 48'd0);
        chk("bp_o_sel", 48'(o_sel), 48'd0);
        @(negedge clk);
        #1;
        chk("bp_in_rdy_hold", 48'(in_rdy), 48'd0);
        chk("bp_out_vld", 48'(out_vld), 48'h7);
        chk("bp_ch1_data", 48'(out_data[15:8]), 48'h41);
        out_rdy = 3'b010;
        send(8'h77, 1);
        out_rdy = 3'b111;
        idle(2);

        // Enable: en=0 blocks acceptance while slots drain.
        out_rdy = 3'b000;
        send(8'h60, 2);
        en      = 1'b0;
        in_vld  = 1'b1;
        in_data = 8'h61;
        out_rdy = 3'b100;
        #1;
        chk("en_in_rdy", 48'(in_rdy), 48'd0);
        chk("en_o_sel", 48'(o_sel), 48'd0);
        @(negedge clk);
        #1;
        chk("en_drained", 48'(out_vld), 48'd0);
        chk("en_in_rdy_hold", 48'(in_rdy), 48'd0);
        @(negedge clk);
        en      = 1'b1;
        out_rdy = 3'b111;
        send(8'h61, 0);
        send(8'h62, 1);
        idle(2);

        // Reset mid-stream with two slots full.
        out_rdy = 3'b000;
        send(8'h70, 2);
        send(8'h71, 0);
        in_vld  = 1'b1;
        in_data = 8'h72;
        #2;
        chk("pre_rst_vld", 48'(out_vld), 48'h5);
        asrst_n = 1'b0;
        #1;
        chk("mid_rst_out_vld", 48'(out_vld), 48'd0);
        chk("mid_rst_in_rdy", 48'(in_rdy), 48'd0);
        chk("mid_rst_o_sel", 48'(o_sel), 48'd0);
        chk("mid_rst_out_data", 48'(out_data), 48'd0);
        flush();
        @(negedge clk);
        asrst_n = 1'b1;
        out_rdy = 3'b111;
        send(8'h11, 0);
        idle(2);

`ifdef RR_DISPATCHER_CNT_EN
        asrst_n = 1'b0;
        flush();
        @(negedge clk);
        asrst_n = 1'b1;
        chk("cnt_rst", 48'(o_cnt), 48'd0);
        out_rdy = 3'b111;
        for (int i = 0; i < 7; i++) begin
            send(8'hC0 + 8'(i), i % 3);
        end
        chk("cnt_7", 48'(o_cnt), {16'd2, 16'd2, 16'd3});
        send(8'hD0, 1);
        send(8'hD1, 2);
        cnt_tmp        = o_cnt;
        cnt_tmp[15:0]  = 16'hFFFF;
        force dut.cnt_q = cnt_tmp;
        #1;
        release dut.cnt_q;
        send(8'hD2, 0);
        chk("cnt_wrap", 48'(o_cnt[15:0]), 48'd0);
        chk("cnt_others", 48'(o_cnt[47:16]), {16'd3, 16'd3});
        idle(2);
`endif

        idle(2);
        chk("q0_empty", 48'(q0.size()), 48'd0);
        chk("q1_empty", 48'(q1.size()), 48'd0);
        chk("q2_empty", 48'(q2.size()), 48'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rr_dispatcher.md
# rr_dispatcher

Round-robin dispatcher: accepts one valid/ready input stream and distributes each accepted word to one of N output channels in fair rotating order, skipping channels whose output slot is occupied. It is the split-side counterpart of the 3-requester round-robin arbiter and sits in front of parallel processing lanes whose results are later merged back through that arbiter. Each channel has a one-entry registered output slot, so the consumer sees a registered output.

## Interface
- `DW`, 8: data width in bits.
- `N`, 3: number of output channels (≥2).
- `clk` in 1: clock, rising edge.
- `asrst_n` in 1: asynchronous reset, active low.
- `en` in 1: dispatch enable; 0 blocks new acceptance. Slots still drain.
- `in_vld` in 1: input word valid.
- `in_data` in DW: input word.
- `in_rdy` out 1: input accepted this cycle when `in_vld & in_rdy`.
- `out_vld` out N: per-channel slot valid.
- `out_data` out N*DW: channel k data at bits [k*DW +: DW].
- `out_rdy` in N: per-channel consumer ready.
- `o_sel` out N: one-hot channel that receives the word on an accept this cycle (combinational). 0 when there is no accept.

## Operation
- **Slot free(k):** `!out_vld[k] | out_rdy[k]` (empty, or draining this cycle).
- **Pointer `last_ptr`:** log2(N) bits. Search order is `last_ptr+1, +2, …` modulo N. The first free channel is selected.
- **Ready:** `in_rdy = en & |free`. No channel is free, or `en`=0 → `in_rdy`=0.
- **Accept (`in_vld & in_rdy`):**
  - Selected slot k loads `in_data` and sets `out_vld[k]`.
  - `last_ptr` ← k.
  - The simultaneous drain of slot k is a load, not a clear.
- **Drain:** slot k not loaded and `out_vld[k] & out_rdy[k]` → `out_vld[k]` clears. `out_data[k]` holds its last value.
- **No accept:** `last_ptr` holds, so the rotation resumes where it stopped.
- **`in_vld` without ready:** the word is not consumed. The upstream holds `in_vld` and `in_data` stable until accepted.
- **Wrap-around:** from `last_ptr`=N-1 the search begins at channel 0.
- **Reset (any time, mid-transfer included):**
  - All slots are emptied and in-flight slot contents are lost.
  - `last_ptr` = N-1, so the first word goes to channel 0.
  - While `asrst_n`=0: `out_vld`=0, `out_data`=0, `in_rdy`=0, `o_sel`=0.

## Timing
- Latency: accept in cycle t → `out_vld[k]`=1 with data from cycle t+1.
- Throughput: 1 word/cycle while any slot is free.
- With all consumers ready constantly, consecutive words go to channels 0,1,2,0,1,…
- Combinational paths: `out_rdy` → `in_rdy` and `o_sel`. Registered: `out_vld`, `out_data`, `last_ptr`.
- `en` is sampled each cycle with no pipeline. Deasserting `en` blocks the accept in the same cycle.

## Configuration
- `RR_DISPATCHER_CNT_EN` defined:
  - Adds output `o_cnt`, N*16 bits: per-channel count of accepted words.
  - Counts increment on accept into channel k, wrap 0xFFFF→0, reset to 0.
- Undefined: no counters and no `o_cnt` port. Dispatch behaviour is identical.

## Structure
- **Package `rr_pkg`:**
  - Default `N`.
  - Pointer width function (`$clog2(N)`).
  - Count width constant 16.
- **Sub-module `rr_dispatch_slot`:**
  - One-entry output register per channel, instantiated N times via generate.
  - Ports: `clk`, `asrst_n`, `load`, `din`, `rdy`, `vld`, `dout`, `free`.
- **Top:** the rotating first-free search, `last_ptr`, and optional counters.

## Test plan
- **Reset:** `asrst_n`=0 mid-stream with 2 slots full → `out_vld`=000 and `in_rdy`=0 immediately. After release, the next word 0x11 → channel 0.
- **Rotation:** `en`=1, `out_rdy`=111, words 0xA0..0xA5 on consecutive cycles → channels 0,1,2,0,1,2, each one cycle after accept. `in_rdy` stays 1 throughout.
- **Skip occupied:** `out_rdy`=000, slot 1 full, `last_ptr`=0, word 0x5A → lands in channel 2 (`o_sel`=100). The next word goes to channel 0. The next `in_rdy`=0.
- **Back-pressure:** all slots full, `out_rdy`=000 → `in_rdy`=0 and input held. Raise `out_rdy[1]` → same-cycle accept into channel 1, `out_vld[1]` stays 1 with new data.
- **Enable:** `en`=0 with `in_vld`=1 → `in_rdy`=0, no slot loads, existing slots drain. `en`=1 → resumes at `last_ptr+1`.
- **`RR_DISPATCHER_CNT_EN`:** dispatch 7 words with all ready → `o_cnt` = {2,2,3} for channels {2,1,0}. Force the channel 0 count to 0xFFFF, then one accept → 0x0000.
